// File: rtl/cpu_defs.sv
// Shared encodings for the operate-instruction path: opcodes, shift kinds,
// sequencer states and status bit positions.
package cpu_defs;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_CMP = 2'b01,
        OP_AND = 2'b10,
        OP_MVN = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    localparam int STATUS_N = 2;
    localparam int STATUS_V = 1;
    localparam int STATUS_Z = 0;

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational barrel-of-one shifter on B followed by the ALU. Flags always
// describe A - shift(B) so the caller decides when they are meaningful.
module alu_shift_unit
    import cpu_defs::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        shift_i,
    input  logic [1:0]        opcode_i,
    output logic [DATA_W-1:0] result_o,
    output logic              n_o,
    output logic              v_o,
    output logic              z_o
);

    logic [DATA_W-1:0] sb;
    logic [DATA_W-1:0] diff;

    always_comb begin
        sb = b_i;
        case (shift_i)
            SH_LSL:  sb = {b_i[DATA_W-2:0], 1'b0};
            SH_LSR:  sb = {1'b0, b_i[DATA_W-1:1]};
            SH_ASR:  sb = {b_i[DATA_W-1], b_i[DATA_W-1:1]};
            default: sb = b_i;
        endcase
    end

    assign diff = a_i - sb;

    always_comb begin
        result_o = a_i + sb;
        case (opcode_i)
            OP_ADD:  result_o = a_i + sb;
            OP_CMP:  result_o = diff;
            OP_AND:  result_o = a_i & sb;
            OP_MVN:  result_o = ~sb;
            default: result_o = a_i + sb;
        endcase
    end

    assign n_o = diff[DATA_W-1];
    assign z_o = (diff == '0);
    assign v_o = (a_i[DATA_W-1] != sb[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequencer that fetches Rn and Rm from the register file, runs shift+ALU and
// writes the result back to Rd; CMP updates status instead of writing.
//
// state     | meaning
// ST_IDLE   | waiting for start, fields captured on start
// ST_READ_A | readnum=rn, A latched on exit
// ST_READ_B | readnum=rm, B latched on exit
// ST_EXEC   | C computed, status updated on exit for CMP
// ST_WRITE  | write-back of C to rd (suppressed for CMP)
// ST_DONE   | one-cycle done pulse
module reg_op_sequencer
    import cpu_defs::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        shift,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [ADDR_W-1:0] readnum,
    output logic [ADDR_W-1:0] writenum,
    output logic              write,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status
);

    seq_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] rn_q, rn_d;
    logic [ADDR_W-1:0] rm_q, rm_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [2:0]        status_q, status_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_n, alu_v, alu_z;

    alu_shift_unit #(.DATA_W(DATA_W)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .shift_i  (sh_q),
        .opcode_i (op_q),
        .result_o (alu_result),
        .n_o      (alu_n),
        .v_o      (alu_v),
        .z_o      (alu_z)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sh_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_d     = sh_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    sh_d    = shift;
                    rn_d    = rn;
                    rm_d    = rm;
                    rd_d    = rd;
                    state_d = ST_READ_A;
                end
            end
            ST_READ_A: begin
                a_d     = rf_data_out;
                state_d = ST_READ_B;
            end
            ST_READ_B: begin
                b_d     = rf_data_out;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                c_d = alu_result;
                if (op_q == OP_CMP) begin
                    status_d[STATUS_N] = alu_n;
                    status_d[STATUS_V] = alu_v;
                    status_d[STATUS_Z] = alu_z;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers so reset clears them asynchronously.
    assign readnum  = (state_q == ST_READ_B) ? rm_q : rn_q;
    assign writenum = rd_q;
    assign data_in  = c_q;
    assign write    = (state_q == ST_WRITE) && (op_q != OP_CMP);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign status   = status_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench: behavioural 8x16 register file around the sequencer,
// hand-computed results, latency and status checks.
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  opcode;
    logic [2:0]  rn, rm, rd;
    logic [1:0]  shift;
    logic [15:0] rf_data_out;
    logic [2:0]  readnum, writenum;
    logic        write;
    logic [15:0] data_in;
    logic        busy, done;
    logic [2:0]  status;

    reg_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .rn          (rn),
        .rm          (rm),
        .rd          (rd),
        .shift       (shift),
        .rf_data_out (rf_data_out),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .status      (status)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8];
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (write) rf[writenum] <= data_in;
        else if (pre_en) rf[pre_addr] <= pre_data;
    end
    assign rf_data_out = rf[readnum];

    int checks = 0;
    int errors = 0;

    int          wr_cnt, wr_j, dn_cnt, dn_j;
    logic [2:0]  wr_num, rd_a, rd_b;
    logic [15:0] wr_data;
    logic        busy_first, busy_last;
    logic [15:0] exp_rf [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_R%0d", tag, i), {16'h0, rf[i]}, {16'h0, exp_rf[i]});
    endtask

    // j counts negedges after the start-sampling edge k; j=3 is cycle k+4.
    task automatic do_op(input logic [1:0] op, input logic [2:0] n, input logic [2:0] m,
                         input logic [2:0] d, input logic [1:0] sh, input bit pulse2);
        wr_cnt = 0; dn_cnt = 0; wr_j = -1; dn_j = -1; wr_num = '0; wr_data = '0;
        @(negedge clk);
        opcode = op; rn = n; rm = m; rd = d; shift = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0) begin rd_a = readnum; busy_first = busy; end
            if (j == 1) rd_b = readnum;
            if (j == 5) busy_last = busy;
            if (write) begin wr_cnt++; wr_j = j; wr_num = writenum; wr_data = data_in; end
            if (done) begin dn_cnt++; dn_j = j; end
            if (pulse2 && j == 1) begin rd = d + 3'd1; opcode = 2'b10; start = 1'b1; end
            if (pulse2 && j == 2) start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; shift = '0;
        rn = '0; rm = '0; rd = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        exp_rf = '{16'd7, 16'd2, 16'd0, 16'h8000, 16'd1, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < 8; i++) preload(3'(i), exp_rf[i]);
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_write", {31'h0, write}, 32'd0);
        check("rst_status", {29'h0, status}, 32'd0);
        check("rst_readnum", {29'h0, readnum}, 32'd0);
        check("rst_writenum", {29'h0, writenum}, 32'd0);
        check("rst_data_in", {16'h0, data_in}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD R2 = R0 + LSL1(R1) = 7 + 4
        do_op(2'b00, 3'd0, 3'd1, 3'd2, 2'b01, 1'b0);
        exp_rf[2] = 16'd11;
        check("add_busy_first", {31'h0, busy_first}, 32'd1);
        check("add_readnum_a", {29'h0, rd_a}, 32'd0);
        check("add_readnum_b", {29'h0, rd_b}, 32'd1);
        check("add_wr_cnt", wr_cnt, 32'd1);
        check("add_wr_cycle", wr_j, 32'd3);
        check("add_writenum", {29'h0, wr_num}, 32'd2);
        check("add_data_in", {16'h0, wr_data}, 32'd11);
        check("add_done_cnt", dn_cnt, 32'd1);
        check("add_done_cycle", dn_j, 32'd4);
        check("add_busy_last", {31'h0, busy_last}, 32'd0);
        check("add_R2", {16'h0, rf[2]}, 32'd11);

        // CMP R3, R4: 0x8000 - 1 overflows
        do_op(2'b01, 3'd3, 3'd4, 3'd0, 2'b00, 1'b0);
        check("cmp1_status", {29'h0, status}, 32'b010);
        check("cmp1_wr_cnt", wr_cnt, 32'd0);
        check("cmp1_done_cycle", dn_j, 32'd4);
        check_rf("cmp1");

        // CMP R0, R0 then ADD R5 = R0 + R0 leaves status alone
        do_op(2'b01, 3'd0, 3'd0, 3'd1, 2'b00, 1'b0);
        check("cmp2_status", {29'h0, status}, 32'b001);
        do_op(2'b00, 3'd0, 3'd0, 3'd5, 2'b00, 1'b0);
        exp_rf[5] = 16'd14;
        check("add2_R5", {16'h0, rf[5]}, 32'd14);
        check("add2_status", {29'h0, status}, 32'b001);

        // MVN R6 = ~ASR1(0x8000); AND R7 = R6 & LSR1(R6)
        preload(3'd1, 16'h8000);
        exp_rf[1] = 16'h8000;
        do_op(2'b11, 3'd0, 3'd1, 3'd6, 2'b11, 1'b0);
        exp_rf[6] = 16'h3FFF;
        check("mvn_data_in", {16'h0, wr_data}, 32'h3FFF);
        check("mvn_R6", {16'h0, rf[6]}, 32'h3FFF);
        do_op(2'b10, 3'd6, 3'd6, 3'd7, 2'b10, 1'b0);
        exp_rf[7] = 16'h1FFF;
        check("and_R7", {16'h0, rf[7]}, 32'h1FFF);
        check("and_status", {29'h0, status}, 32'b001);
        check_rf("logic");

        // Reset while ADD R2 is in EXEC
        @(negedge clk);
        opcode = 2'b00; rn = 3'd0; rm = 3'd1; rd = 3'd2; shift = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec_busy_before", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_write", {31'h0, write}, 32'd0);
        check("abort_status", {29'h0, status}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_R2", {16'h0, rf[2]}, 32'd11);
        do_op(2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0);
        exp_rf[2] = 16'h8007;
        check("post_abort_wr_cycle", wr_j, 32'd3);
        check("post_abort_done_cycle", dn_j, 32'd4);
        check("post_abort_R2", {16'h0, rf[2]}, 32'h8007);

        // Second start while busy must be ignored
        do_op(2'b00, 3'd0, 3'd0, 3'd3, 2'b00, 1'b1);
        exp_rf[3] = 16'd14;
        check("busy_start_wr_cnt", wr_cnt, 32'd1);
        check("busy_start_writenum", {29'h0, wr_num}, 32'd3);
        check("busy_start_done_cnt", dn_cnt, 32'd1);
        check("busy_start_busy_last", {31'h0, busy_last}, 32'd0);
        check("busy_start_status", {29'h0, status}, 32'd0);
        check_rf("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
